// File: rtl/riscv_sim_monitor.sv
// riscv_sim_monitor: end-of-run monitor that watches writeback retire lanes for halt/illegal,
// drains a fixed number of cycles, then raises sticky done and a one-cycle stop pulse.
module riscv_sim_monitor #(
    parameter int NUM_LANES = 1,
    parameter int OPCODE_WIDTH = 7,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 7'b1110011,
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int CNT_WIDTH = 32,
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_LANES-1:0]              wb_valid,
    input  logic [NUM_LANES*OPCODE_WIDTH-1:0] wb_opcode,
    input  logic [NUM_LANES-1:0]              wb_illegal,
    output logic                              done,
    output logic                              stop,
    output logic [1:0]                        halt_cause,
    output logic [LW-1:0]                     halt_lane,
    output logic [CNT_WIDTH-1:0]              cycle_count,
    output logic [CNT_WIDTH-1:0]              retire_count
);
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [DW-1:0]        r_drain;
    logic [CNT_WIDTH-1:0] r_cycle;
    logic [CNT_WIDTH-1:0] r_retire;
    logic [1:0]           r_cause;
    logic [LW-1:0]        r_lane;
    logic                 r_stop;
    logic                 w_hit;
    logic                 w_ill;
    logic [LW-1:0]        w_win;
    logic [CNT_WIDTH-1:0] w_add;
    logic                 w_timeout;

    assign w_timeout = r_cycle == CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    // Scan upward: lanes below the first trigger are counted, the trigger and above are not.
    always_comb begin
        w_hit = 1'b0;
        w_ill = 1'b0;
        w_win = '0;
        w_add = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!w_hit && wb_valid[i] &&
                (wb_illegal[i] || wb_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] == HALT_OPCODE)) begin
                w_hit = 1'b1;
                w_ill = wb_illegal[i];
                w_win = LW'(i);
            end else if (!w_hit && wb_valid[i]) begin
                w_add = w_add + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_RUN)
            w_next = w_hit ? ((DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN) : (w_timeout ? S_DONE : S_RUN);
        else if (r_state == S_DRAIN)
            w_next = (r_drain == '0) ? S_DONE : S_DRAIN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_drain  <= '0;
            r_cycle  <= '0;
            r_retire <= '0;
            r_cause  <= 2'b00;
            r_lane   <= '0;
            r_stop   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_stop  <= (w_next == S_DONE) && (r_state != S_DONE);
            if (r_state == S_RUN) begin
                r_cycle  <= r_cycle + CNT_WIDTH'(1);
                r_retire <= r_retire + w_add;
                if (w_hit) begin
                    r_cause <= w_ill ? 2'b10 : 2'b01;
                    r_lane  <= w_win;
                    r_drain <= DW'(DRAIN_CYCLES - 1);
                end else if (w_timeout) begin
                    r_cause <= 2'b11;
                    r_lane  <= '0;
                end
            end else if (r_state == S_DRAIN && r_drain != '0) begin
                r_drain <= r_drain - DW'(1);
            end
        end
    end

    assign done         = r_state == S_DONE;
    assign stop         = r_stop;
    assign halt_cause   = r_cause;
    assign halt_lane    = r_lane;
    assign cycle_count  = r_cycle;
    assign retire_count = r_retire;
endmodule

// File: doc/riscv_sim_monitor.md
Name: riscv_sim_monitor

Overview:
- Synthesizable end-of-run monitor for the pipelined riscv core.
- Watches the writeback-stage retire lanes and detects a halt opcode or an illegal instruction.
- After detection, drains a programmable number of cycles, then raises sticky done plus a one-cycle stop pulse.
- Also counts cycles and retired instructions, and enforces a cycle-timeout watchdog. Benches poll done/stop instead of open-coding stop logic.

Parameters:
NUM_LANES, 1, number of writeback retire lanes (1..4)
OPCODE_WIDTH, 7, opcode field width per lane
HALT_OPCODE, 7'b1110011, opcode treated as halt (SYSTEM/ecall)
DRAIN_CYCLES, 3, cycles from trigger to done (0 allowed)
TIMEOUT_CYCLES, 200, RUN-state cycle limit before forced done
CNT_WIDTH, 32, width of cycle and retire counters

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
wb_valid  input  NUM_LANES  lane i retires an instruction this cycle
wb_opcode  input  NUM_LANES*OPCODE_WIDTH  lane i opcode at bits [i*OPCODE_WIDTH +: OPCODE_WIDTH]
wb_illegal  input  NUM_LANES  lane i instruction flagged illegal by decode
done  output  1  sticky, high in DONE state
stop  output  1  one-cycle pulse on the cycle done first rises
halt_cause  output  2  00 none, 01 halt opcode, 10 illegal, 11 timeout
halt_lane  output  clog2(NUM_LANES) (min 1)  lane index of the trigger
cycle_count  output  CNT_WIDTH  cycles spent in RUN
retire_count  output  CNT_WIDTH  instructions retired before the trigger

Behaviour:
- Reset (checked at posedge clk while reset=1) values: state=RUN, done=0, stop=0, halt_cause=00, halt_lane=0, cycle_count=0, retire_count=0, drain counter=0. Reset wins over every other event, including mid-DRAIN and in DONE.
- Per-lane trigger: trig[i] = wb_valid[i] & (wb_illegal[i] | opcode_i==HALT_OPCODE). wb_illegal is ignored when wb_valid=0.
- Cause priority within a lane: illegal (10) over halt opcode (01).
- Across lanes: the lowest-indexed triggering lane wins.
- RUN:
  - cycle_count += 1 every cycle.
  - No trigger: retire_count += popcount(wb_valid).
  - Trigger: add only the valid lanes with index < winning lane; the trigger lane itself is not counted. Latch halt_cause/halt_lane.
  - Trigger with DRAIN_CYCLES=0: go to DONE. Otherwise load drain=DRAIN_CYCLES-1 and go to DRAIN.
  - Timeout: no trigger and cycle_count==TIMEOUT_CYCLES-1 -> cause 11, halt_lane=0, go to DONE.
  - Trigger and timeout in the same cycle: trigger wins.
- Increments: cycle_count counts that final cycle; RUN counters wrap modulo 2^CNT_WIDTH.
- DRAIN:
  - cycle_count and retire_count frozen; wb_* inputs ignored.
  - drain==0 -> DONE, else drain -= 1.
- DONE:
  - done=1, held until reset.
  - stop=1 only on the first DONE cycle.
  - All counters and cause fields frozen.
- Latency: trigger sampled at edge T -> done=1 and stop=1 visible after edge T+DRAIN_CYCLES (registered outputs).
- Timeout: done=1 after the edge on which cycle_count reaches TIMEOUT_CYCLES.
- halt_cause/halt_lane are valid from the first non-RUN cycle onward; they read 00/0 while in RUN.

Test Plan:
- Single lane, DRAIN_CYCLES=3: 5 retires of opcode 0110011, then halt 1110011 at cycle 6 -> retire_count=5, cause=01, lane=0; done and stop rise exactly 3 cycles after the trigger edge; stop high 1 cycle; done stays 1 for 10+ cycles.
- NUM_LANES=2: lane0 valid ADD and lane1 valid illegal+halt in the same cycle, after 4 prior dual retires -> retire_count=9, cause=10, halt_lane=1.
- NUM_LANES=2: both lanes trigger (lane0 halt, lane1 illegal) -> halt_lane=0, cause=01, retire_count unchanged by that cycle.
- TIMEOUT_CYCLES=20, no trigger -> done after the 20th RUN cycle, cause=11, cycle_count=20; a trigger arriving on cycle 20 instead -> cause=01, enters DRAIN.
- DRAIN_CYCLES=0: halt -> done and stop on the very next cycle.
- Reset mid-DRAIN and again in DONE -> all outputs return to reset values next cycle; a second program halts normally with fresh counts.
